// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the FIFO burst reader slice.
package fifo_reader_pkg;

    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } reader_state_t;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Bus bundles for the burst reader: FIFO read side (FWFT) and downstream valid/ready stream.
interface fifo_rd_if #(
    parameter int WIDTH = 8
);
    logic             pop;
    logic             empty;
    logic [WIDTH-1:0] data;

    modport master (output pop, input empty, input data);
    modport slave  (input pop, output empty, output data);
endinterface

interface stream_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fifo_burst_reader_skid_buf.sv
// Two-entry head/skid output buffer; space and out_valid come straight from registers.
module stream_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_space,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_drained
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_skid;
    logic [1:0]       r_occ;
    logic             r_valid;
    logic             r_space;
    logic [WIDTH-1:0] w_head_next;
    logic [WIDTH-1:0] w_skid_next;
    logic [1:0]       w_occ_next;
    logic             w_xfer;

    // Next head/skid/occupancy from the incoming pop and outgoing transfer.
    always_comb begin
        w_xfer      = r_valid && i_out_ready;
        w_head_next = r_head;
        w_skid_next = r_skid;
        w_occ_next  = r_occ;
        case (r_occ)
            2'd0: begin
                if (i_in_valid) begin
                    w_head_next = i_in_data;
                    w_occ_next  = 2'd1;
                end else begin
                    w_occ_next  = 2'd0;
                end
            end
            2'd1: begin
                case ({i_in_valid, w_xfer})
                    2'b10: begin
                        w_skid_next = i_in_data;
                        w_occ_next  = 2'd2;
                    end
                    2'b11: begin
                        w_head_next = i_in_data;
                        w_occ_next  = 2'd1;
                    end
                    2'b01: begin
                        w_occ_next  = 2'd0;
                    end
                    default: begin
                        w_occ_next  = 2'd1;
                    end
                endcase
            end
            2'd2: begin
                if (w_xfer) begin
                    w_head_next = r_skid;
                    w_occ_next  = 2'd1;
                end else begin
                    w_occ_next  = 2'd2;
                end
            end
            default: begin
                w_occ_next = 2'd0;
            end
        endcase
    end

    // Buffer registers; valid and space are kept as flops so no handshake input reaches them combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= {WIDTH{1'b0}};
            r_skid  <= {WIDTH{1'b0}};
            r_occ   <= 2'd0;
            r_valid <= 1'b0;
            r_space <= 1'b1;
        end else begin
            r_head  <= w_head_next;
            r_skid  <= w_skid_next;
            r_occ   <= w_occ_next;
            r_valid <= (w_occ_next != 2'd0);
            r_space <= (w_occ_next != 2'd2);
        end
    end

    assign o_space     = r_space;
    assign o_out_valid = r_valid;
    assign o_out_data  = r_head;
    assign o_drained   = (w_occ_next == 2'd0);

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst reader: drains i_burst_len words from a FWFT FIFO into a valid/ready stream.
// Optional stall counter output is enabled by defining READER_STALL_CNT_EN.
module fifo_burst_reader
    import fifo_reader_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LENW  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [LENW-1:0]        i_burst_len,
    output logic                   o_busy,
    output logic                   o_done,
`ifdef READER_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0] o_stall_cnt,
`endif
    fifo_rd_if.master              fifo,
    stream_if.master               strm
);

    localparam logic [1:0]      ST_IDLE  = IDLE;
    localparam logic [1:0]      ST_RUN   = RUN;
    localparam logic [1:0]      ST_DRAIN = DRAIN;
    localparam logic [1:0]      ST_DONE  = DONE;
    localparam logic [LENW-1:0] REM_ZERO = {LENW{1'b0}};
    localparam logic [LENW-1:0] REM_ONE  = {{(LENW-1){1'b0}}, 1'b1};

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [LENW-1:0] r_rem;
    logic [LENW-1:0] w_rem_next;
    logic            r_busy;
    logic            r_done;
    logic            w_pop;
    logic            w_space;
    logic            w_drained;
    logic            w_out_valid;

    stream_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid_buf (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (w_pop),
        .i_in_data   (fifo.data),
        .o_space     (w_space),
        .o_out_valid (w_out_valid),
        .i_out_ready (strm.ready),
        .o_out_data  (strm.data),
        .o_drained   (w_drained)
    );

    // Pop uses only registered state plus fifo.empty, keeping out_ready off this path.
    always_comb begin
        w_pop = (r_state == ST_RUN) && !fifo.empty && (r_rem != REM_ZERO) && w_space;
    end

    // Burst sequencing and remaining-word count.
    always_comb begin
        w_state_next = r_state;
        w_rem_next   = r_rem;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_burst_len != REM_ZERO) begin
                        w_rem_next   = i_burst_len;
                        w_state_next = ST_RUN;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_pop) begin
                    w_rem_next = r_rem - REM_ONE;
                    if (r_rem == REM_ONE) begin
                        w_state_next = ST_DRAIN;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (w_drained) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, count and status flops; busy/done are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_rem   <= REM_ZERO;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_rem   <= w_rem_next;
            r_busy  <= (w_state_next != ST_IDLE);
            r_done  <= (w_state_next == ST_DONE);
        end
    end

    assign fifo.pop   = w_pop;
    assign strm.valid = w_out_valid;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

`ifdef READER_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic                   w_start_acc;

    assign w_start_acc = (r_state == ST_IDLE) && i_start;

    // Saturating count of cycles where a word waits on downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= {STALL_CNT_W{1'b0}};
        end else if (w_start_acc) begin
            r_stall_cnt <= {STALL_CNT_W{1'b0}};
        end else if (w_out_valid && !strm.ready && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomised and directed bench for fifo_burst_reader against a queue-based reference model.
module tb_fifo_burst_reader;

    localparam int WIDTH = 8;
    localparam int LENW  = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [LENW-1:0] burst_len = '0;
    logic            busy;
    logic            done;
`ifdef READER_STALL_CNT_EN
    logic [15:0]     stall_cnt;
`endif

    fifo_rd_if #(.WIDTH(WIDTH)) fif ();
    stream_if  #(.WIDTH(WIDTH)) sif ();

    fifo_burst_reader #(
        .WIDTH (WIDTH),
        .LENW  (LENW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
        .i_burst_len (burst_len),
        .o_busy      (busy),
        .o_done      (done),
`ifdef READER_STALL_CNT_EN
        .o_stall_cnt (stall_cnt),
`endif
        .fifo        (fif),
        .strm        (sif)
    );

    always #5 clk = ~clk;

    // Environment FIFO: first-word-fall-through over a circular array.
    logic [7:0]  mem [0:255];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    logic        s_pop = 1'b0;

    always_comb begin
        fif.empty = (rd_ptr == wr_ptr);
        fif.data  = mem[rd_ptr[7:0]];
    end

    initial begin
        forever begin
            @(posedge clk);
            if (s_pop && (rd_ptr != wr_ptr)) rd_ptr <= rd_ptr + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 reading, 2 draining, 3 done pulse.
    int         m_phase = 0;
    int         m_rem   = 0;
    int         m_stall = 0;
    logic [7:0] m_buf [$];
    bit         m_armed = 1'b0;
    int         n_pop   = 0;
    int         n_done  = 0;
    logic [7:0] log_q [$];

    initial begin
        forever begin
            bit         exp_valid;
            bit         exp_pop;
            logic [7:0] head_word;
            @(negedge clk);
            exp_valid = (m_buf.size() != 0);
            exp_pop   = (m_phase == 1) && (rd_ptr != wr_ptr) && (m_rem != 0) && (m_buf.size() < 2);
            if (m_armed) begin
                chk("busy", busy, m_phase != 0);
                chk("done", done, m_phase == 3);
                chk("fifo_pop", fif.pop, exp_pop);
                chk("out_valid", sif.valid, exp_valid);
                if (exp_valid) chk("out_data", sif.data, m_buf[0]);
`ifdef READER_STALL_CNT_EN
                chk("stall_cnt", stall_cnt, m_stall);
`endif
                if (fif.pop) n_pop = n_pop + 1;
                if (done) n_done = n_done + 1;
                if (sif.valid && sif.ready) log_q.push_back(sif.data);
            end
            s_pop     = fif.pop;
            head_word = mem[rd_ptr[7:0]];
            if (rst) begin
                m_phase = 0;
                m_rem   = 0;
                m_stall = 0;
                m_buf.delete();
                m_armed = 1'b1;
            end else begin
                if (exp_valid && sif.ready) void'(m_buf.pop_front());
                if (exp_valid && !sif.ready && m_stall < 65535) m_stall = m_stall + 1;
                if (exp_pop) begin
                    m_buf.push_back(head_word);
                    m_rem = m_rem - 1;
                end
                case (m_phase)
                    0: if (start) begin
                        m_stall = 0;
                        if (burst_len != 0) begin
                            m_rem   = int'(burst_len);
                            m_phase = 1;
                        end else begin
                            m_phase = 3;
                        end
                    end
                    1: if (exp_pop && m_rem == 0) m_phase = 2;
                    2: if (m_buf.size() == 0) m_phase = 3;
                    default: m_phase = 0;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        mem[wr_ptr[7:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic go(input logic [7:0] len);
        start     = 1'b1;
        burst_len = len;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int k;
        k = 0;
        do begin
            tick();
            k = k + 1;
        end while (busy && k < lim);
        chk("idle_timeout", busy, 1'b0);
    endtask

    function automatic int get_log(input int idx);
        if (idx >= 0 && idx < log_q.size()) return int'(log_q[idx]);
        return -1;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pb, db, lb, k;
        sif.ready = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pop", fif.pop, 1'b0);
        chk("rst_valid", sif.valid, 1'b0);
        chk("rst_data", sif.data, 8'h00);
`ifdef READER_STALL_CNT_EN
        chk("rst_stall", stall_cnt, 16'h0000);
`endif
        rst = 1'b0;
        tick();

        // Basic burst of five words at full rate.
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
        pb = n_pop; db = n_done; lb = log_q.size();
        go(8'd5);
        wait_idle(40);
        chk("t1_pops", n_pop - pb, 5);
        chk("t1_done", n_done - db, 1);
        chk("t1_nwords", log_q.size() - lb, 5);
        for (int i = 0; i < 5; i++) chk("t1_word", get_log(lb + i), 32'h10 + i);
        chk("t1_fifo_empty", fif.empty, 1'b1);

        // Backpressure: six stalled cycles once data appears.
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
        sif.ready = 1'b0;
        pb = n_pop; lb = log_q.size();
        go(8'd4);
        k = 0;
        while (!sif.valid && k < 20) begin
            tick();
            k = k + 1;
        end
        chk("t2_valid_seen", sif.valid, 1'b1);
        repeat (6) tick();
        chk("t2_pops_stalled", n_pop - pb, 2);
        chk("t2_hold", sif.data, 8'h10);
        sif.ready = 1'b1;
        wait_idle(40);
        chk("t2_pops", n_pop - pb, 4);
        for (int i = 0; i < 4; i++) chk("t2_word", get_log(lb + i), 32'h10 + i);
`ifdef READER_STALL_CNT_EN
        chk("t2_stall_cnt", stall_cnt, 16'd6);
`endif

        // FIFO runs dry mid-burst.
        push(8'h20); push(8'h21);
        pb = n_pop; lb = log_q.size();
        go(8'd3);
        repeat (10) tick();
        chk("t3_busy_wait", busy, 1'b1);
        chk("t3_pops_wait", n_pop - pb, 2);
        push(8'h22);
        wait_idle(30);
        chk("t3_pops", n_pop - pb, 3);
        chk("t3_word2", get_log(lb + 2), 32'h22);

        // Zero-length burst.
        pb = n_pop; db = n_done;
        go(8'd0);
        wait_idle(10);
        chk("t4_pops", n_pop - pb, 0);
        chk("t4_done", n_done - db, 1);

        // Start while busy is ignored.
        push(8'h30); push(8'h31); push(8'h32);
        pb = n_pop; lb = log_q.size();
        go(8'd3);
        start = 1'b1; burst_len = 8'd7;
        tick();
        start = 1'b0;
        wait_idle(40);
        chk("t5_pops", n_pop - pb, 3);
        chk("t5_word0", get_log(lb), 32'h30);
        chk("t5_word2", get_log(lb + 2), 32'h32);

        // Reset mid-burst, then a fresh burst of two.
        for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
        db = n_done;
        go(8'd8);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("t6_busy_rst", busy, 1'b0);
        chk("t6_valid_rst", sif.valid, 1'b0);
        rst = 1'b0;
        repeat (3) tick();
        chk("t6_no_done", n_done - db, 0);
        go(8'd2);
        wait_idle(30);
        chk("t6_done", n_done - db, 1);
        chk("t6_word_a", get_log(log_q.size() - 2), 32'h43);
        chk("t6_word_b", get_log(log_q.size() - 1), 32'h44);

        // Random traffic, starts, readiness and occasional resets.
        for (int c = 0; c < 2500; c++) begin
            sif.ready = ($urandom_range(3) != 0);
            if ($urandom_range(2) == 0 && (wr_ptr - rd_ptr) < 200) push(8'($urandom_range(255)));
            start     = ($urandom_range(9) == 0);
            burst_len = 8'($urandom_range(12));
            rst       = ($urandom_range(299) == 0);
            tick();
        end
        start = 1'b0;
        rst   = 1'b0;
        sif.ready = 1'b1;
        for (int i = 0; i < 13; i++) push(8'($urandom_range(255)));
        wait_idle(200);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
